// File: rtl/image_pipe_fifo.sv
// DEPTH-entry pixel FIFO between an upstream source and the IPM. It has an optional
// inversion stage on output load and a CPU register block. IMAGE_PIPE_FIFO_WMARK_EN adds a peak-occupancy register.
module image_pipe_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] image_pipe_data_in,
   input  logic          image_pipe_valid_in,
   input  logic          image_pipe_end_in,
   output logic          image_pipe_busy_out,
   output logic [DW-1:0] ipm_data_out,
   output logic          ipm_valid_out,
   output logic          ipm_end_out,
   input  logic          ipm_busy_in,
   input  logic          reg_cpu_cs,
   input  logic [29:0]   reg_cpu_addr,
   input  logic [31:0]   reg_cpu_data_wr,
   output logic [31:0]   reg_cpu_data_rd,
   input  logic          reg_cpu_we,
   output logic          reg_cpu_wack,
   input  logic          reg_cpu_re,
   output logic          reg_cpu_rdv
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] HIGH_CNT = (AW+1)'(DEPTH - 1);

   logic [DW:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          out_vld_q, out_vld_d, out_end_q, out_end_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          inv_q, inv_d, ovf_q, ovf_d, end_seen_q, end_seen_d;
   logic [31:0]   beat_cnt_q, beat_cnt_d, frame_cnt_q, frame_cnt_d;
   logic          wack_q, wack_d, rdv_q, rdv_d, re_prev_q, re_prev_d;
   logic [31:0]   rd_data_q, rd_data_d, rd_mux;
`ifdef IMAGE_PIPE_FIFO_WMARK_EN
   logic [AW:0]   wmark_q, wmark_d;
`endif

   logic [13:0] reg_idx;
   logic        wr_stb, rd_stb, flush, full, empty, accept, pop, push;
   logic [DW:0] head;
   logic        unused_bits;

   assign reg_idx     = reg_cpu_addr[13:0];
   assign wr_stb      = reg_cpu_cs & reg_cpu_we;
   assign rd_stb      = reg_cpu_cs & reg_cpu_re & ~re_prev_q;
   assign flush       = wr_stb && (reg_idx == 14'd0) && reg_cpu_data_wr[0];
   assign full        = (cnt_q == FULL_CNT);
   assign empty       = (cnt_q == '0);
   assign accept      = out_vld_q & ~ipm_busy_in;
   // Flush overrides both FIFO ends in its cycle: nothing is popped and the input beat is discarded.
   assign pop         = ~empty && (~out_vld_q || ~ipm_busy_in) && ~flush;
   assign push        = image_pipe_valid_in && (~full || pop) && ~flush;
   assign head        = mem_q[rd_ptr_q];
   assign unused_bits = ^{reg_cpu_addr[29:14], reg_cpu_data_wr[31:17], reg_cpu_data_wr[15:2]};

   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         14'd0: rd_mux[1] = inv_q;
         14'd1: begin
            rd_mux[AW:0] = cnt_q;
            rd_mux[8]    = empty;
            rd_mux[9]    = full;
            rd_mux[16]   = ovf_q;
         end
         14'd2: rd_mux = beat_cnt_q;
         14'd3: rd_mux = frame_cnt_q;
`ifdef IMAGE_PIPE_FIFO_WMARK_EN
         14'd4: rd_mux[AW:0] = wmark_q;
`endif
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      out_vld_d   = out_vld_q;
      out_end_d   = out_end_q;
      out_data_d  = out_data_q;
      inv_d       = inv_q;
      ovf_d       = ovf_q;
      end_seen_d  = end_seen_q;
      beat_cnt_d  = beat_cnt_q;
      frame_cnt_d = frame_cnt_q;
      wack_d      = wr_stb;
      rdv_d       = reg_cpu_cs & reg_cpu_re;
      re_prev_d   = reg_cpu_re;
      rd_data_d   = rd_stb ? rd_mux : rd_data_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
      busy_d = (cnt_d >= HIGH_CNT);

      if (flush) begin
         out_vld_d  = 1'b0;
         out_end_d  = 1'b0;
         out_data_d = '0;
      end else if (pop) begin
         out_vld_d  = 1'b1;
         out_end_d  = head[DW];
         out_data_d = inv_q ? ~head[DW-1:0] : head[DW-1:0];
      end else if (accept) begin
         out_vld_d  = 1'b0;
         out_end_d  = 1'b0;
         out_data_d = '0;
      end

      if (wr_stb && (reg_idx == 14'd0)) inv_d = reg_cpu_data_wr[1];
      // Clear first so that a same-cycle overflow leaves the flag set.
      if (wr_stb && (reg_idx == 14'd1) && reg_cpu_data_wr[16]) ovf_d = 1'b0;
      if (image_pipe_valid_in && full && ~pop && ~flush) ovf_d = 1'b1;

      if (accept) begin
         if (end_seen_q) begin
            beat_cnt_d = '0;
            end_seen_d = 1'b0;
         end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
         end
         if (out_end_q) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            end_seen_d  = 1'b1;
         end
      end
   end

`ifdef IMAGE_PIPE_FIFO_WMARK_EN
   always_comb begin
      wmark_d = (cnt_q > wmark_q) ? cnt_q : wmark_q;
      if (wr_stb && (reg_idx == 14'd4)) wmark_d = cnt_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {image_pipe_end_in, image_pipe_data_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         out_vld_q   <= 1'b0;
         out_end_q   <= 1'b0;
         out_data_q  <= '0;
         inv_q       <= 1'b0;
         ovf_q       <= 1'b0;
         end_seen_q  <= 1'b0;
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
         wack_q      <= 1'b0;
         rdv_q       <= 1'b0;
         re_prev_q   <= 1'b0;
         rd_data_q   <= '0;
`ifdef IMAGE_PIPE_FIFO_WMARK_EN
         wmark_q     <= '0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         out_vld_q   <= out_vld_d;
         out_end_q   <= out_end_d;
         out_data_q  <= out_data_d;
         inv_q       <= inv_d;
         ovf_q       <= ovf_d;
         end_seen_q  <= end_seen_d;
         beat_cnt_q  <= beat_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         wack_q      <= wack_d;
         rdv_q       <= rdv_d;
         re_prev_q   <= re_prev_d;
         rd_data_q   <= rd_data_d;
`ifdef IMAGE_PIPE_FIFO_WMARK_EN
         wmark_q     <= wmark_d;
`endif
      end
   end

   assign image_pipe_busy_out = busy_q;
   assign ipm_data_out        = out_data_q;
   assign ipm_valid_out       = out_vld_q;
   assign ipm_end_out         = out_end_q;
   assign reg_cpu_wack        = wack_q;
   assign reg_cpu_rdv         = rdv_q;
   assign reg_cpu_data_rd     = rd_data_q;
endmodule

// File: tb/tb_image_pipe_fifo.sv
// Directed testbench for image_pipe_fifo (DEPTH=8, DW=32). Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_image_pipe_fifo;
   localparam int DW = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] data_in;
   logic          valid_in, end_in, busy_out;
   logic [DW-1:0] data_out;
   logic          valid_out, end_out, busy_in;
   logic          cs, we, re, wack, rdv;
   logic [29:0]   addr;
   logic [31:0]   wdata, rdata;

   int n_checks = 0;
   int n_errors = 0;

   image_pipe_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .image_pipe_data_in(data_in), .image_pipe_valid_in(valid_in),
      .image_pipe_end_in(end_in), .image_pipe_busy_out(busy_out),
      .ipm_data_out(data_out), .ipm_valid_out(valid_out),
      .ipm_end_out(end_out), .ipm_busy_in(busy_in),
      .reg_cpu_cs(cs), .reg_cpu_addr(addr), .reg_cpu_data_wr(wdata),
      .reg_cpu_data_rd(rdata), .reg_cpu_we(we), .reg_cpu_wack(wack),
      .reg_cpu_re(re), .reg_cpu_rdv(rdv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid_in = 1'b0; end_in = 1'b0; data_in = '0; busy_in = 1'b0;
      cs = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic reg_write(input logic [29:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      check("wack", 32'(wack), 32'd1);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic reg_read(input logic [29:0] a, output logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; re = 1'b1; addr = a;
      @(negedge clk);
      check("rdv", 32'(rdv), 32'd1);
      d = rdata;
      cs = 1'b0; re = 1'b0;
   endtask

   task automatic wait_vld(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (valid_out) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rv;
      logic [31:0] exp_d [6];
      bit          exp_v [6];
      int          got, nbeats, nends;
      bit          ok;

      do_reset();
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_data", data_out, 32'd0);
      check("rst_end", 32'(end_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
      reg_read(30'd1, rv);
      check("rst_status", rv, 32'h0000_0100);
      reg_read(30'd3, rv);
      check("rst_frame", rv, 32'd0);

      // Three back-to-back beats appear two cycles later, contiguously.
      exp_v = '{0, 0, 1, 1, 1, 0};
      exp_d = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("lat_valid", 32'(valid_out), 32'(exp_v[k]));
         check("lat_data", data_out, exp_d[k]);
         valid_in = (k < 3);
         data_in  = (k < 3) ? 32'h11 * (k + 1) : 32'h0;
      end

      // Stalled output: beat 0 sits in the output register, eight more fill the FIFO,
      // the tenth is dropped.
      busy_in = 1'b1;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k == 7) check("busy_before", 32'(busy_out), 32'd0);
         if (k == 8) check("busy_after", 32'(busy_out), 32'd1);
         valid_in = (k < 10);
         data_in  = 32'hA0 + k;
      end
      valid_in = 1'b0;
      check("hold_valid", 32'(valid_out), 32'd1);
      check("hold_data", data_out, 32'hA0);
      reg_read(30'd1, rv);
      check("status_full_ovf", rv, 32'h0001_0208);
      reg_write(30'd1, 32'h0001_0000);
      reg_read(30'd1, rv);
      check("status_ovf_clr", rv, 32'h0000_0208);
      busy_in = 1'b0;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         if (valid_out) begin
            if (got < 10) check("drain_data", data_out, 32'hA0 + got);
            got++;
         end
         @(negedge clk);
      end
      check("drain_count", got, 32'd9);

      // Four-beat frame, with a stray end_in (no valid) before it.
      do_reset();
      @(negedge clk);
      end_in = 1'b1; valid_in = 1'b0;
      nbeats = 0; nends = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (valid_out) begin
            nbeats++;
            check("end_flag", 32'(end_out), 32'(data_out == 32'hC3));
            if (end_out) nends++;
         end
         valid_in = (k < 4);
         data_in  = 32'hC0 + k;
         end_in   = (k == 3);
      end
      check("frame_beats", nbeats, 32'd4);
      check("frame_ends", nends, 32'd1);
      reg_read(30'd3, rv);
      check("frame_cnt", rv, 32'd1);
      reg_read(30'd2, rv);
      check("beat_cnt", rv, 32'd4);
      @(negedge clk);
      valid_in = 1'b1; data_in = 32'hD0; end_in = 1'b0;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (3) @(negedge clk);
      reg_read(30'd2, rv);
      check("beat_cnt_clr", rv, 32'd0);
      reg_read(30'd3, rv);
      check("frame_cnt_hold", rv, 32'd1);

      // Inversion on load.
      reg_write(30'd0, 32'h2);
      reg_read(30'd0, rv);
      check("ctrl_inv", rv, 32'h2);
      @(negedge clk);
      valid_in = 1'b1; data_in = 32'h0000_00FF;
      @(negedge clk);
      valid_in = 1'b0;
      wait_vld(ok);
      check("inv_seen", 32'(ok), 32'd1);
      check("inv_data", data_out, 32'hFFFF_FF00);
      reg_write(30'd0, 32'h0);

      // Flush with queued beats, a held output beat and a simultaneous push.
      busy_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         valid_in = 1'b1; data_in = 32'hE0 + k;
      end
      @(negedge clk);
      valid_in = 1'b0;
      reg_read(30'd1, rv);
      check("status_occ4", rv, 32'h0000_0004);
      check("pre_flush_data", data_out, 32'hE0);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = 30'd0; wdata = 32'h1;
      valid_in = 1'b1; data_in = 32'hEE;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; valid_in = 1'b0;
      check("flush_valid", 32'(valid_out), 32'd0);
      check("flush_data", data_out, 32'd0);
      check("flush_busy", 32'(busy_out), 32'd0);
      reg_read(30'd1, rv);
      check("flush_status", rv, 32'h0000_0100);
      reg_read(30'd0, rv);
      check("ctrl_selfclr", rv, 32'h0);
      busy_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("flush_quiet", 32'(valid_out), 32'd0);
      end

      reg_write(30'd7, 32'hFFFF_FFFF);
      reg_read(30'd7, rv);
      check("unmapped", rv, 32'd0);
`ifdef IMAGE_PIPE_FIFO_WMARK_EN
      // Seven beats under stall leave six in the FIFO.
      do_reset();
      busy_in = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         valid_in = 1'b1; data_in = 32'h50 + k;
      end
      @(negedge clk);
      valid_in = 1'b0; busy_in = 1'b0;
      repeat (12) @(negedge clk);
      reg_read(30'd4, rv);
      check("wmark_peak", rv, 32'd6);
      reg_write(30'd4, 32'h0);
      reg_read(30'd4, rv);
      check("wmark_clr", rv, 32'd0);
`else
      reg_read(30'd4, rv);
      check("wmark_absent", rv, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
